// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Counter encodings, BTB entry layout and indexing-mode selectors.
package bp_pkg;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t SNT = 2'd0;
  localparam cnt2_t WNT = 2'd1;
  localparam cnt2_t WT  = 2'd2;
  localparam cnt2_t ST  = 2'd3;

  localparam int unsigned BP_BIMODAL = 0;
  localparam int unsigned BP_GSHARE  = 1;

  // Widest PC the BTB entry can hold; tags are stored zero-extended.
  localparam int unsigned BP_MAX_ADDR_WIDTH = 32;

  typedef struct packed {
    logic                         valid;
    logic [BP_MAX_ADDR_WIDTH-1:0] tag;
    logic [BP_MAX_ADDR_WIDTH-1:0] target;
    logic                         jump;
  } btb_entry_t;

  function automatic cnt2_t sat_update(cnt2_t cnt, logic taken);
    cnt2_t res;
    if (taken) begin
      res = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      res = (cnt == SNT) ? SNT : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / Execute resolution bundle between the pipeline and the predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 16
);

  logic                  clear_i;
  logic [ADDR_WIDTH-1:0] pc_f_i;
  logic                  pred_taken_o;
  logic [ADDR_WIDTH-1:0] pred_target_o;
  logic [IDX_WIDTH-1:0]  pred_idx_o;

  logic                  upd_valid_i;
  logic [ADDR_WIDTH-1:0] upd_pc_i;
  logic [IDX_WIDTH-1:0]  upd_idx_i;
  logic                  upd_is_branch_i;
  logic                  upd_is_jump_i;
  logic                  upd_taken_i;
  logic [ADDR_WIDTH-1:0] upd_target_i;
  logic                  upd_pred_taken_i;
  logic [ADDR_WIDTH-1:0] upd_pred_target_i;

  logic                  mispredict_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic [CNT_WIDTH-1:0]  branch_cnt_o;
  logic [CNT_WIDTH-1:0]  mispred_cnt_o;

  modport master (
    output clear_i, pc_f_i,
    output upd_valid_i, upd_pc_i, upd_idx_i, upd_is_branch_i, upd_is_jump_i,
    output upd_taken_i, upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, pred_idx_o,
    input  mispredict_o, redirect_pc_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  clear_i, pc_f_i,
    input  upd_valid_i, upd_pc_i, upd_idx_i, upd_is_branch_i, upd_is_jump_i,
    input  upd_taken_i, upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, pred_idx_o,
    output mispredict_o, redirect_pc_o, branch_cnt_o, mispred_cnt_o
  );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read port, one registered write port.
// A write replaces whatever entry currently occupies the index.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] rd_pc_i,
  output logic                  rd_hit_o,
  output logic [ADDR_WIDTH-1:0] rd_target_o,
  output logic                  rd_jump_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_pc_i,
  input  logic [ADDR_WIDTH-1:0] wr_target_i,
  input  logic                  wr_jump_i
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  btb_entry_t                   mem_q [ENTRIES];
  btb_entry_t                   rd_entry;
  logic [IdxW-1:0]              rd_idx;
  logic [IdxW-1:0]              wr_idx;
  logic [BP_MAX_ADDR_WIDTH-1:0] rd_tag;
  logic [BP_MAX_ADDR_WIDTH-1:0] wr_tag;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  assign rd_idx = rd_pc_i[IdxW+1:2];
  assign wr_idx = wr_pc_i[IdxW+1:2];
  assign rd_tag = BP_MAX_ADDR_WIDTH'(rd_pc_i >> (IdxW + 2));
  assign wr_tag = BP_MAX_ADDR_WIDTH'(wr_pc_i >> (IdxW + 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx] <= '{valid:  1'b1,
                         tag:    wr_tag,
                         target: BP_MAX_ADDR_WIDTH'(wr_target_i),
                         jump:   wr_jump_i};
    end
  end

  assign rd_entry    = mem_q[rd_idx];
  assign rd_hit_o    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_target_o = rd_entry.target[ADDR_WIDTH-1:0];
  assign rd_jump_o   = rd_entry.jump;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB plus 2-bit PHT with bimodal or gshare indexing.
// Lookup is combinational; resolution, training and redirect come from Execute.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned MODE        = 0,
  parameter int unsigned HIST_BITS   = 6,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned PhtIdxW = $clog2(PHT_ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] InstBytes = ADDR_WIDTH'(4);

  cnt2_t                 pht_q [PHT_ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic                  btb_hit;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  btb_jump;
  logic [PhtIdxW-1:0]    lookup_idx;
  logic [PhtIdxW-1:0]    hist_idx;
  logic                  pred_taken;

  logic                  upd_cf;
  logic                  upd_branch;
  logic                  btb_we;
  logic                  mispredict;

  // ---------------------------------------------------------------- lookup
  assign hist_idx   = (MODE == BP_GSHARE) ? PhtIdxW'(ghr_q) : '0;
  assign lookup_idx = bp.pc_f_i[PhtIdxW+1:2] ^ hist_idx;
  assign pred_taken = btb_hit && (btb_jump || pht_q[lookup_idx][1]);

  assign bp.pred_taken_o  = pred_taken;
  assign bp.pred_target_o = pred_taken ? btb_target : bp.pc_f_i + InstBytes;
  assign bp.pred_idx_o    = lookup_idx;

  // ------------------------------------------------------------ resolution
  assign upd_cf     = bp.upd_valid_i && (bp.upd_is_branch_i || bp.upd_is_jump_i);
  assign upd_branch = bp.upd_valid_i && bp.upd_is_branch_i;
  assign mispredict = upd_cf &&
                      ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                       (bp.upd_taken_i && (bp.upd_target_i != bp.upd_pred_target_i)));

  assign bp.mispredict_o  = mispredict;
  assign bp.redirect_pc_o = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + InstBytes;

  // Only taken control flow allocates; not-taken branches leave the BTB alone.
  assign btb_we = bp.upd_valid_i &&
                  ((bp.upd_is_branch_i && bp.upd_taken_i) || bp.upd_is_jump_i);

  bp_btb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ENTRIES    (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (bp.clear_i),
    .rd_pc_i     (bp.pc_f_i),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .rd_jump_o   (btb_jump),
    .wr_en_i     (btb_we),
    .wr_pc_i     (bp.upd_pc_i),
    .wr_target_i (bp.upd_target_i),
    .wr_jump_i   (bp.upd_is_jump_i)
  );

  // ---------------------------------------------------------------- training
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= WNT;
      end
    end else if (bp.clear_i) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= WNT;
      end
    end else if (upd_branch) begin
      pht_q[bp.upd_idx_i] <= sat_update(pht_q[bp.upd_idx_i], bp.upd_taken_i);
    end
  end

  always_comb begin
    ghr_d         = ghr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_branch) begin
      ghr_d = {ghr_q[HIST_BITS-2:0], bp.upd_taken_i};
    end
    if (upd_cf && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
    // Clear wins over any same-cycle resolution.
    if (bp.clear_i) begin
      ghr_d         = '0;
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.branch_cnt_o  = branch_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a bimodal and a gshare instance driven by directed
// vectors; expectations are queued at stimulus time and checked by a negedge monitor.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_WIDTH(32), .IDX_WIDTH(6), .CNT_WIDTH(16)) bi ();
  branch_predictor_if #(.ADDR_WIDTH(32), .IDX_WIDTH(6), .CNT_WIDTH(16)) gi ();

  branch_predictor #(
    .ADDR_WIDTH(32), .BTB_ENTRIES(16), .PHT_ENTRIES(64),
    .MODE(BP_BIMODAL), .HIST_BITS(6), .CNT_WIDTH(16)
  ) u_bim (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bi)
  );

  branch_predictor #(
    .ADDR_WIDTH(32), .BTB_ENTRIES(16), .PHT_ENTRIES(64),
    .MODE(BP_GSHARE), .HIST_BITS(6), .CNT_WIDTH(16)
  ) u_gsh (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (gi)
  );

  typedef enum int {SigTaken, SigTarget, SigIdx, SigMis, SigRedir, SigBcnt, SigMcnt} sig_e;
  typedef struct {
    string       name;
    bit          gs;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(bit gs, sig_e sig);
    logic [31:0] a;
    a = '0;
    case (sig)
      SigTaken:  a = 32'(gs ? gi.pred_taken_o  : bi.pred_taken_o);
      SigTarget: a = gs ? gi.pred_target_o : bi.pred_target_o;
      SigIdx:    a = 32'(gs ? gi.pred_idx_o    : bi.pred_idx_o);
      SigMis:    a = 32'(gs ? gi.mispredict_o  : bi.mispredict_o);
      SigRedir:  a = gs ? gi.redirect_pc_o : bi.redirect_pc_o;
      SigBcnt:   a = 32'(gs ? gi.branch_cnt_o  : bi.branch_cnt_o);
      SigMcnt:   a = 32'(gs ? gi.mispred_cnt_o : bi.mispred_cnt_o);
      default:   a = '0;
    endcase
    return a;
  endfunction

  // Monitor: compare every queued expectation at the falling edge.
  exp_t        mon_e;
  logic [31:0] mon_a;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = actual(mon_e.gs, mon_e.sig);
      checks++;
      if (mon_a !== mon_e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_e.name, mon_a, mon_e.val);
      end
    end
  end

  // Branch and jump flags together are never legal on a resolution.
  always @(negedge clk) begin
    if (bi.upd_valid_i && bi.upd_is_branch_i && bi.upd_is_jump_i) begin
      errors++;
      $display("FAIL illegal_flags_bim: branch and jump both set");
    end
    if (gi.upd_valid_i && gi.upd_is_branch_i && gi.upd_is_jump_i) begin
      errors++;
      $display("FAIL illegal_flags_gsh: branch and jump both set");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(string name, bit gs, sig_e sig, logic [31:0] val);
    exp_t e;
    e.name = name; e.gs = gs; e.sig = sig; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit gs);
    if (gs) begin
      gi.clear_i = 0; gi.upd_valid_i = 0; gi.upd_is_branch_i = 0; gi.upd_is_jump_i = 0;
    end else begin
      bi.clear_i = 0; bi.upd_valid_i = 0; bi.upd_is_branch_i = 0; bi.upd_is_jump_i = 0;
    end
  endtask

  task automatic look(bit gs, logic [31:0] pc);
    if (gs) gi.pc_f_i = pc;
    else    bi.pc_f_i = pc;
  endtask

  task automatic resolve(bit gs, logic [31:0] pc, bit br, bit jp, bit tk, logic [31:0] tgt,
                         bit ptk, logic [31:0] ptgt, logic [5:0] idx);
    if (gs) begin
      gi.upd_valid_i = 1; gi.upd_pc_i = pc; gi.upd_is_branch_i = br; gi.upd_is_jump_i = jp;
      gi.upd_taken_i = tk; gi.upd_target_i = tgt; gi.upd_pred_taken_i = ptk;
      gi.upd_pred_target_i = ptgt; gi.upd_idx_i = idx;
    end else begin
      bi.upd_valid_i = 1; bi.upd_pc_i = pc; bi.upd_is_branch_i = br; bi.upd_is_jump_i = jp;
      bi.upd_taken_i = tk; bi.upd_target_i = tgt; bi.upd_pred_taken_i = ptk;
      bi.upd_pred_target_i = ptgt; bi.upd_idx_i = idx;
    end
  endtask

  task automatic chk_pred(string n, bit gs, bit tk, logic [31:0] tgt);
    push_exp({n, "_taken"}, gs, SigTaken, 32'(tk));
    push_exp({n, "_target"}, gs, SigTarget, tgt);
  endtask

  task automatic chk_res(string n, bit gs, bit mis, logic [31:0] redir);
    push_exp({n, "_mispredict"}, gs, SigMis, 32'(mis));
    if (mis) push_exp({n, "_redirect"}, gs, SigRedir, redir);
  endtask

  task automatic chk_cnt(string n, bit gs, int b, int m);
    push_exp({n, "_branch_cnt"}, gs, SigBcnt, 32'(b));
    push_exp({n, "_mispred_cnt"}, gs, SigMcnt, 32'(m));
  endtask

  localparam logic [5:0] HistSeq [6] = '{6'd1, 6'd2, 6'd5, 6'd10, 6'd21, 6'd42};

  initial begin
    logic [5:0] prev_hist;
    idle(0); idle(1);
    look(0, 32'h100); look(1, 32'h100);
    resolve(0, 0, 0, 0, 0, 0, 0, 0, 0); resolve(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(1);
    step(); step();
    rst_n = 1'b1;

    // 1: reset state
    chk_pred("reset", 0, 0, 32'h104);
    push_exp("reset_idx", 0, SigIdx, 0);
    push_exp("reset_mis", 0, SigMis, 0);
    chk_cnt("reset", 0, 0, 0);
    step();

    // 2: train 0x100 taken -> 0x80 twice; same-cycle lookup sees old contents
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
    chk_pred("same_cycle", 0, 0, 32'h104);
    chk_res("first_taken", 0, 1, 32'h80);
    step();
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0);
    chk_pred("after_one", 0, 1, 32'h80);
    chk_res("second_taken", 0, 0, 0);
    chk_cnt("after_one", 0, 1, 1);
    step();
    idle(0);
    chk_pred("after_two", 0, 1, 32'h80);
    chk_cnt("after_two", 0, 2, 1);
    step();

    // 3: saturate then walk down
    for (int i = 0; i < 3; i++) begin
      resolve(0, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0);
      chk_res("sat_taken", 0, 0, 0);
      step();
    end
    resolve(0, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
    chk_res("nt1", 0, 1, 32'h104);
    chk_cnt("before_nt1", 0, 5, 1);
    step();
    resolve(0, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
    chk_pred("still_taken", 0, 1, 32'h80);
    chk_res("nt2", 0, 1, 32'h104);
    chk_cnt("before_nt2", 0, 6, 2);
    step();
    idle(0);
    chk_pred("now_nt", 0, 0, 32'h104);
    chk_cnt("after_nt2", 0, 7, 3);
    step();

    // 5: aliasing, 0x140 evicts 0x100
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
    chk_res("retrain", 0, 1, 32'h80);
    step();
    resolve(0, 32'h140, 1, 0, 1, 32'h300, 0, 32'h144, 6'h10);
    chk_pred("pre_evict", 0, 1, 32'h80);
    chk_res("alias_train", 0, 1, 32'h300);
    chk_cnt("pre_evict", 0, 8, 4);
    step();
    idle(0);
    look(0, 32'h140);
    chk_pred("alias_hit", 0, 1, 32'h300);
    chk_cnt("alias", 0, 9, 5);
    step();
    look(0, 32'h100);
    chk_pred("evicted", 0, 0, 32'h104);
    step();
    for (int i = 0; i < 2; i++) begin
      resolve(0, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0);
      chk_res("nt_correct", 0, 0, 0);
      step();
    end
    idle(0);
    chk_pred("nt_no_alloc", 0, 0, 32'h104);
    chk_cnt("nt_no_alloc", 0, 11, 5);
    step();

    // 4: JAL 0x200 -> 0x400 with PHT entry at SNT
    resolve(0, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204, 0);
    chk_res("jal_first", 0, 1, 32'h400);
    step();
    idle(0);
    look(0, 32'h200);
    chk_pred("jal_hit", 0, 1, 32'h400);
    push_exp("jal_idx", 0, SigIdx, 0);
    chk_cnt("jal", 0, 12, 6);
    step();
    resolve(0, 32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 0);
    chk_res("jal_correct", 0, 0, 0);
    step();
    resolve(0, 32'h200, 0, 1, 1, 32'h400, 1, 32'h404, 0);
    chk_res("jal_bad_target", 0, 1, 32'h400);
    chk_cnt("jal_bad_target", 0, 13, 6);
    step();
    resolve(0, 32'h500, 0, 0, 1, 32'h900, 0, 32'h504, 0);
    chk_res("non_cf", 0, 0, 0);
    step();
    idle(0);
    chk_cnt("non_cf", 0, 14, 7);
    chk_pred("jal_still", 0, 1, 32'h400);
    step();

    // clear with a same-cycle update
    bi.clear_i = 1;
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
    step();
    idle(0);
    chk_pred("clear_jal", 0, 0, 32'h204);
    chk_cnt("clear", 0, 0, 0);
    step();
    look(0, 32'h100);
    chk_pred("clear_no_train", 0, 0, 32'h104);
    step();
    resolve(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
    chk_res("post_clear", 0, 1, 32'h80);
    step();
    idle(0);
    chk_pred("pht_weak_after_clear", 0, 1, 32'h80);
    chk_cnt("post_clear", 0, 1, 1);
    step();

    // asynchronous reset pulse between edges
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk_pred("async_rst", 0, 0, 32'h104);
    chk_cnt("async_rst", 0, 0, 0);
    step();

    // 6: gshare history
    look(1, 32'h100);
    push_exp("gs_reset_idx", 1, SigIdx, 0);
    step();
    prev_hist = 0;
    for (int i = 0; i < 6; i++) begin
      resolve(1, 32'h300, 1, 0, (i % 2) == 0, 32'h40, 0, 32'h304, 0);
      push_exp("gs_hist_idx", 1, SigIdx, 32'(prev_hist));
      step();
      prev_hist = HistSeq[i];
    end
    idle(1);
    push_exp("gs_ghr_101010", 1, SigIdx, 32'h2A);
    chk_cnt("gs", 1, 6, 3);
    step();
    look(1, 32'h104);
    push_exp("gs_idx_104", 1, SigIdx, 32'h2B);
    step();
    gi.clear_i = 1;
    resolve(1, 32'h300, 1, 0, 1, 32'h40, 0, 32'h304, 0);
    chk_res("gs_clear_mis", 1, 1, 32'h40);
    step();
    idle(1);
    look(1, 32'h100);
    push_exp("gs_clear_idx", 1, SigIdx, 0);
    chk_cnt("gs_clear", 1, 0, 0);
    step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
